core_regs_sb: RTL
=================

Name: core_regs_sb

Overview:
- Next-generation core register file: NUM_REGS x WIDTH, NUM_RD read ports, NUM_WR write ports.
- Registered (1-cycle) reads with write-first same-cycle forwarding.
- Integrated scoreboard: a busy bit per register, set by issue-time reservations and cleared by writeback, exposed on every read port.
- Sits between decode/issue (read, reserve) and the writeback stage (write ports). Replaces the fixed 4R/2W file.

Parameters:
- NUM_REGS, 16, number of architectural registers (power of two, >= 2).
- WIDTH, 32, register data width in bits.
- NUM_RD, 4, number of read ports (>= 1).
- NUM_WR, 2, number of write ports (>= 1).
- NUM_RSV, 2, number of reservation ports (>= 1).
- R0_ZERO, 0, if 1 then register 0 always reads 0, ignores writes and reservations, and is never busy.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_r  in  NUM_RD x RW  read register numbers; RW = $clog2(NUM_REGS).
- rd_value  out  NUM_RD x WIDTH  read data, valid the cycle after rd_r.
- rd_busy  out  NUM_RD  busy bit of the register read, same timing as rd_value.
- wr_ready  in  NUM_WR  write enable per write port.
- wr_rd  in  NUM_WR x RW  write destination.
- wr_value  in  NUM_WR x WIDTH  write data.
- rsv_valid  in  NUM_RSV  reserve request per reservation port.
- rsv_rd  in  NUM_RSV x RW  register to mark busy.
- busy_vec  out  NUM_REGS  current scoreboard state (registered).
- err_wr_idle  out  1  sticky flag: a write hit a non-busy register.

Behaviour:
- Reset (async, rst_n=0):
  - all registers = 0; busy_vec = 0;
  - rd_value = 0; rd_busy = 0; err_wr_idle = 0.
  - Reset asserted mid-operation discards all in-flight state immediately.
- Read latency is 1 cycle. For rd_r[i] sampled at edge T, rd_value[i] after T = file[rd_r[i]] including every write committed at T (write-first bypass).
- Outputs are registered and hold their value while inputs are unchanged; no combinational path from input to output.
- Write conflict: two or more wr_ready ports with the same wr_rd in one cycle -> the highest-index port wins, both for the file and for the bypass.
- Scoreboard update at each edge, applied in this order:
  1. busy[r] cleared for every r written this cycle.
  2. busy[r] set for every r reserved this cycle.
- Reserve and writeback to the same register in one cycle -> busy stays 1, since the new producer wins.
- Duplicate reserve ports with the same register act as a single reservation.
- rd_busy[i] reflects busy after that same edge's update, consistent with rd_value.
- err_wr_idle is set when wr_ready[k] targets a register whose busy bit was 0 before the edge and that is not reserved in the same cycle. It clears only on reset.
- R0_ZERO=1: register 0 reads 0 and is never busy. Writes to register 0 are dropped and do not raise err_wr_idle. Reservations of register 0 are ignored.
- No stall or backpressure; every request is accepted every cycle.

Decomposition:
- Shared package (core/uarch.sv):
  - add a parametric wb_line variant (ready, rd, value);
  - add the RW derivation constant;
  - keep word, reg_num and `NUM_GPREGS as the default binding of NUM_REGS / WIDTH.
- One sub-module, core_regs_sb_bypass, instanced per read port. It does priority selection of the matching write-port value over the file value and computes the next busy bit for that address.
- The scoreboard update stays inline.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> rd_value=0, rd_busy=0, busy_vec=0, err_wr_idle=0. Deassert, then read r5 -> 0 next cycle.
- Write then read: write r3=0xDEADBEEF at T, read r3 at T+1 -> rd_value=0xDEADBEEF at T+2. Same-cycle read of r3 at T -> 0xDEADBEEF at T+1 (bypass).
- Write conflict: port0 r7=0x11 and port1 r7=0x22 in the same cycle -> subsequent reads of r7 = 0x22, including the bypass read.
- Scoreboard sequence on r4:
  - reserve at T -> busy_vec[4]=1 after T;
  - writeback r4 at T+3 -> busy 0, no error;
  - reserve and write r4 together -> busy stays 1.
- Error flag: write r9 while not busy and not reserved -> err_wr_idle=1 and stays 1 across later clean traffic until rst_n=0.
- R0_ZERO=1: write r0=0xFFFFFFFF and reserve r0 -> reads of r0 return 0, rd_busy=0, err_wr_idle=0.

Source files
------------

// File: rtl/core_regs_sb_pkg.sv
// Shared micro-architecture definitions for the core register file.
//   reg_bits()  : register-number width for a given register count
//   NUM_GPREGS  : default architectural register count
//   WORD_W      : default data width
//   word        : default data word type
//   reg_num     : default register-number type
//   wb_line     : writeback line (ready, rd, value) at the default widths
package core_regs_sb_pkg;

  // Width of a register number. A single register still needs one bit so
  // that port vectors never collapse to zero width.
  function automatic int reg_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_GPREGS = 16;
  localparam int WORD_W     = 32;

  typedef logic [WORD_W-1:0]               word;
  typedef logic [reg_bits(NUM_GPREGS)-1:0] reg_num;

  // Writeback line at the default binding. Parameterised instances carry
  // the same three fields as separate packed port vectors.
  typedef struct packed {
    logic   ready;
    reg_num rd;
    word    value;
  } wb_line;

endpackage

// File: rtl/core_regs_sb_bypass.sv
// Per-read-port forwarding and next-busy computation.
//   addr       : register number being read
//   file_value : current file contents at addr (pre-edge)
//   busy_cur   : current scoreboard bit at addr
//   rsv_hit    : addr is reserved this cycle (already filtered for r0)
//   wr_*       : all write ports of this cycle
//   value_next : value the read port shows after the edge
//   busy_next  : busy bit the read port shows after the edge
module core_regs_sb_bypass
  import core_regs_sb_pkg::*;
#(
  parameter int NUM_REGS = NUM_GPREGS,
  parameter int WIDTH    = WORD_W,
  parameter int NUM_WR   = 2,
  parameter int R0_ZERO  = 0,
  localparam int RW      = reg_bits(NUM_REGS)
) (
  input  logic [RW-1:0]                 addr,
  input  logic [WIDTH-1:0]              file_value,
  input  logic                          busy_cur,
  input  logic                          rsv_hit,
  input  logic [NUM_WR-1:0]             wr_ready,
  input  logic [NUM_WR-1:0][RW-1:0]     wr_rd,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_value,
  output logic [WIDTH-1:0]              value_next,
  output logic                          busy_next
);

  logic hit;

  always_comb begin
    value_next = file_value;
    hit        = 1'b0;
    // Ascending scan: the highest-index matching port is the last to assign.
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_ready[k] && (wr_rd[k] == addr)) begin
        value_next = wr_value[k];
        hit        = 1'b1;
      end
    end
    // Clear-then-set: a reservation in the same cycle as the writeback wins.
    busy_next = (busy_cur & ~hit) | rsv_hit;
    if ((R0_ZERO != 0) && (addr == '0)) begin
      value_next = '0;
      busy_next  = 1'b0;
    end
  end

endmodule

// File: rtl/core_regs_sb.sv
// Core register file with integrated scoreboard.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rd_r        : read register numbers (NUM_RD ports)
//   rd_value    : read data, one cycle after rd_r, write-first
//   rd_busy     : busy bit of the register read, aligned with rd_value
//   wr_ready    : write enables (NUM_WR ports), highest index wins conflicts
//   wr_rd       : write destinations
//   wr_value    : write data
//   rsv_valid   : reservation requests (NUM_RSV ports)
//   rsv_rd      : registers to mark busy
//   busy_vec    : registered scoreboard state
//   err_wr_idle : sticky, a write targeted a register that was not busy
module core_regs_sb
  import core_regs_sb_pkg::*;
#(
  parameter int NUM_REGS = NUM_GPREGS,
  parameter int WIDTH    = WORD_W,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int NUM_RSV  = 2,
  parameter int R0_ZERO  = 0,
  localparam int RW      = reg_bits(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD-1:0][RW-1:0]     rd_r,
  output logic [NUM_RD-1:0][WIDTH-1:0]  rd_value,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [NUM_WR-1:0]             wr_ready,
  input  logic [NUM_WR-1:0][RW-1:0]     wr_rd,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_value,
  input  logic [NUM_RSV-1:0]            rsv_valid,
  input  logic [NUM_RSV-1:0][RW-1:0]    rsv_rd,
  output logic [NUM_REGS-1:0]           busy_vec,
  output logic                          err_wr_idle
);

  logic [WIDTH-1:0]             regs [NUM_REGS];
  logic [WIDTH-1:0]             wr_data [NUM_REGS];
  logic [NUM_REGS-1:0]          busy_reg;
  logic [NUM_REGS-1:0]          busy_next;
  logic [NUM_REGS-1:0]          wr_hit;
  logic [NUM_REGS-1:0]          rsv_hit;
  logic                         err_reg;
  logic                         err_set;
  logic [NUM_RD-1:0][WIDTH-1:0] rd_value_reg;
  logic [NUM_RD-1:0]            rd_busy_reg;
  logic [WIDTH-1:0]             byp_value [NUM_RD];
  logic                         byp_busy  [NUM_RD];

  // Write decode, reservation decode and scoreboard update.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    err_set = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_data[r] = regs[r];
    end
    // Later ports overwrite earlier ones, so the highest index wins.
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_ready[k] && !((R0_ZERO != 0) && (wr_rd[k] == '0))) begin
        wr_hit[wr_rd[k]]  = 1'b1;
        wr_data[wr_rd[k]] = wr_value[k];
      end
    end
    for (int k = 0; k < NUM_RSV; k++) begin
      if (rsv_valid[k] && !((R0_ZERO != 0) && (rsv_rd[k] == '0))) begin
        rsv_hit[rsv_rd[k]] = 1'b1;
      end
    end
    // A write to an idle register is only legal if a producer claims it
    // in the same cycle.
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_ready[k] && !((R0_ZERO != 0) && (wr_rd[k] == '0)) &&
          !busy_reg[wr_rd[k]] && !rsv_hit[wr_rd[k]]) begin
        err_set = 1'b1;
      end
    end
    busy_next = (busy_reg & ~wr_hit) | rsv_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_data[r];
        end
      end
      busy_reg <= busy_next;
      err_reg  <= err_reg | err_set;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      core_regs_sb_bypass #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH),
        .NUM_WR   (NUM_WR),
        .R0_ZERO  (R0_ZERO)
      ) u_bypass (
        .addr       (rd_r[gi]),
        .file_value (regs[rd_r[gi]]),
        .busy_cur   (busy_reg[rd_r[gi]]),
        .rsv_hit    (rsv_hit[rd_r[gi]]),
        .wr_ready   (wr_ready),
        .wr_rd      (wr_rd),
        .wr_value   (wr_value),
        .value_next (byp_value[gi]),
        .busy_next  (byp_busy[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_value_reg <= '0;
      rd_busy_reg  <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        rd_value_reg[i] <= byp_value[i];
        rd_busy_reg[i]  <= byp_busy[i];
      end
    end
  end

  assign rd_value    = rd_value_reg;
  assign rd_busy     = rd_busy_reg;
  assign busy_vec    = busy_reg;
  assign err_wr_idle = err_reg;

endmodule
